spi_divider: RTL and testbench



---
 rtl/spi_divider_pkg.sv | 20 ++
 rtl/spi_if.sv | 12 +
 rtl/spi_divider_core.sv | 65 ++++++
 rtl/spi_divider.sv | 94 +++++++++
 tb/tb_spi_divider.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/spi_divider_pkg.sv
// rtl/spi_divider_pkg.sv - shared widths, packet layout and FSM encoding for the SPI divider
package spi_divider_pkg;
  localparam int REGISTER_SIZE    = 8;
  localparam int DIV_NSS_POSITION = 3;

  // Field order gives mode at the MSB, dividend in the low bits (LSB-first on the wire).
  typedef struct packed {
    logic                     mode;
    logic [REGISTER_SIZE-1:0] divisor;
    logic [REGISTER_SIZE-1:0] dividend;
  } DivPacket;

  typedef enum logic [4:0] {
    IDLE      = 5'b00001,
    RECEIVING = 5'b00010,
    COMPUTE   = 5'b00100,
    START     = 5'b01000,
    SENDING   = 5'b10000
  } div_state_t;
endpackage

// File: rtl/spi_if.sv
// rtl/spi_if.sv - shared SPI bus between the processor master and its peripherals
interface spi_if #(
  parameter int NssWidth = 8
);
  logic                sclk;
  logic                mosi;
  logic                miso;
  logic [NssWidth-1:0] nss;

  modport master     (output sclk, output mosi, output nss, input miso);
  modport peripheral (input sclk, input mosi, input nss, output miso);
endinterface

// File: rtl/spi_divider_core.sv
// rtl/spi_divider_core.sv - sequential restoring divider, one quotient bit per cycle, MSB first
module div_core
  import spi_divider_pkg::*;
#(
  parameter int Width = REGISTER_SIZE
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [Width-1:0] i_dividend,
  input  logic [Width-1:0] i_divisor,
  output logic [Width-1:0] o_quotient,
  output logic [Width-1:0] o_remainder,
  output logic             o_done
);
  localparam int CntW = $clog2(Width + 1);

  logic             busy;
  logic [CntW-1:0]  steps_left;
  logic [Width-1:0] rem, quo, dvd, dvs;
  logic [Width-1:0] cur_rem, cur_quo, cur_dvd, cur_dvs, diff_lo, next_rem;
  logic [Width:0]   trial;
  logic             qbit;

  // The start cycle performs the first step straight from the inputs. A zero divisor
  // needs no special case: every compare succeeds (quotient all ones) and the
  // remainder ends up holding the shifted-in dividend.
  always_comb begin
    cur_rem  = i_start ? '0 : rem;
    cur_quo  = i_start ? '0 : quo;
    cur_dvd  = i_start ? i_dividend : dvd;
    cur_dvs  = i_start ? i_divisor : dvs;
    trial    = {cur_rem, cur_dvd[Width-1]};
    qbit     = trial >= {1'b0, cur_dvs};
    diff_lo  = Width'(trial - {1'b0, cur_dvs});
    next_rem = qbit ? diff_lo : trial[Width-1:0];
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      busy       <= 1'b0;
      steps_left <= '0;
      rem        <= '0;
      quo        <= '0;
      dvd        <= '0;
      dvs        <= '0;
    end else if (i_start || busy) begin
      rem <= next_rem;
      quo <= {cur_quo[Width-2:0], qbit};
      dvd <= {cur_dvd[Width-2:0], 1'b0};
      dvs <= cur_dvs;
      if (i_start) begin
        steps_left <= CntW'(Width - 1);
        busy       <= 1'b1;
      end else begin
        steps_left <= steps_left - 1'b1;
        busy       <= (steps_left != CntW'(1));
      end
    end
  end

  assign o_done      = busy && (steps_left == CntW'(1));
  assign o_quotient  = quo;
  assign o_remainder = rem;
endmodule

// File: rtl/spi_divider.sv
// rtl/spi_divider.sv - SPI framing around div_core: receive operands, divide, send result
module spi_divider
  import spi_divider_pkg::*;
#(
  parameter int Width       = REGISTER_SIZE,
  parameter int NssPosition = DIV_NSS_POSITION
) (
  input  logic      i_clock,
  input  logic      i_reset,
  spi_if.peripheral spi,
  output logic      o_busy
);
  localparam int PktW = 2 * Width + 1;
  localparam int CntW = $clog2(PktW);
  localparam int IdxW = $clog2(Width);

  div_state_t       state;
  logic [CntW-1:0]  counter;
  logic [PktW-1:0]  packet;
  logic             miso_q, div_start, div_done, selected;
  logic [Width-1:0] quotient, remainder, result;

  assign selected = ~spi.nss[NssPosition];
  assign result   = packet[2*Width] ? remainder : quotient;

  div_core #(.Width(Width)) u_core (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_start    (div_start),
    .i_dividend (packet[Width-1:0]),
    .i_divisor  (packet[2*Width-1:Width]),
    .o_quotient (quotient),
    .o_remainder(remainder),
    .o_done     (div_done)
  );

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state     <= IDLE;
      counter   <= '0;
      packet    <= '0;
      miso_q    <= 1'b0;
      div_start <= 1'b0;
    end else begin
      div_start <= 1'b0;
      if (!selected && state != IDLE) begin
        state   <= IDLE;
        counter <= '0;
        packet  <= '0;
        miso_q  <= 1'b0;
      end else begin
        case (state)
          IDLE: if (selected && spi.mosi) begin
            state   <= RECEIVING;
            counter <= '0;
          end
          RECEIVING: begin
            packet[counter] <= spi.mosi;
            counter         <= counter + 1'b1;
            if (counter == CntW'(2 * Width)) begin
              state     <= COMPUTE;
              counter   <= '0;
              div_start <= 1'b1;
            end
          end
          COMPUTE: if (div_done) begin
            state  <= START;
            miso_q <= 1'b1;
          end
          START: begin
            state   <= SENDING;
            miso_q  <= result[0];
            counter <= CntW'(1);
          end
          SENDING: begin
            // counter holds the index of the next bit to present
            if (counter == CntW'(Width)) begin
              state   <= IDLE;
              counter <= '0;
              miso_q  <= 1'b0;
            end else begin
              miso_q  <= result[counter[IdxW-1:0]];
              counter <= counter + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign spi.miso = selected ? miso_q : 1'bz;
  assign o_busy   = (state != IDLE);
endmodule

// File: tb/tb_spi_divider.sv
// tb/tb_spi_divider.sv - randomized scoreboard bench for spi_divider
module tb_spi_divider;
  import spi_divider_pkg::*;

  localparam int W   = REGISTER_SIZE;
  localparam int NSS = DIV_NSS_POSITION;

  typedef struct {
    logic [W-1:0] result;
    int           start_cyc;
    string        name;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   pushed = 0;
  int   frames_done = 0;
  exp_t exp_q[$];

  spi_if #(.NssWidth(8)) spi ();
  assign spi.sclk = clk;

  spi_divider #(.Width(W), .NssPosition(NSS)) dut (
    .i_clock(clk),
    .i_reset(rst),
    .spi    (spi.peripheral),
    .o_busy (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  function automatic logic [W-1:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
    if (b == 0) return m ? a : {W{1'b1}};
    return m ? a % b : a / b;
  endfunction

  // Monitor: a frame begins when miso goes high while busy (the START marker).
  initial begin
    exp_t         e;
    logic [W-1:0] got;
    int           t;
    forever begin
      @(negedge clk);
      if (!rst && busy && spi.miso === 1'b1) begin
        t = cyc;
        for (int i = 0; i < W; i++) begin
          @(negedge clk);
          got[i] = spi.miso;
        end
        @(negedge clk);
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check({e.name, " start_cycle"}, t, e.start_cyc);
          check({e.name, " result"}, {24'd0, got}, {24'd0, e.result});
          check({e.name, " busy_after"}, {31'd0, busy}, 0);
        end
        frames_done++;
      end
    end
  end

  task automatic send_packet(input DivPacket p, output int t0);
    @(negedge clk);
    spi.nss[NSS] = 1'b0;
    spi.mosi     = 1'b1;
    t0           = cyc + 1;
    for (int i = 0; i < 2 * W + 1; i++) begin
      @(negedge clk);
      spi.mosi = p[i];
    end
    @(negedge clk);
    spi.mosi = 1'b0;
  endtask

  task automatic run_txn(input string name, input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
    DivPacket p;
    exp_t     e;
    int       t0;
    int       guard;
    p = '{mode: m, divisor: b, dividend: a};
    send_packet(p, t0);
    e.result    = ref_div(a, b, m);
    e.start_cyc = t0 + 3 * W + 1;
    e.name      = name;
    exp_q.push_back(e);
    pushed++;
    guard = 0;
    while (frames_done < pushed && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (frames_done < pushed) begin
      check({name, " timeout"}, 0, 1);
      exp_q.delete();
      pushed = frames_done;
    end
  endtask

  initial begin
    DivPacket p;
    int       t0;
    logic [W-1:0] a, b;
    logic         m;

    spi.nss  = '1;
    spi.mosi = 1'b0;
    repeat (3) @(negedge clk);
    spi.nss[NSS] = 1'b0;
    #1;
    check("reset busy", {31'd0, busy}, 0);
    check("reset miso selected", {31'd0, spi.miso}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle miso", {31'd0, spi.miso}, 0);
    check("idle busy", {31'd0, busy}, 0);

    run_txn("100/7 quo", 8'd100, 8'd7, 1'b0);
    run_txn("100/7 rem", 8'd100, 8'd7, 1'b1);
    run_txn("37/0 quo", 8'd37, 8'd0, 1'b0);
    run_txn("37/0 rem", 8'd37, 8'd0, 1'b1);
    run_txn("255/1 quo", 8'd255, 8'd1, 1'b0);
    run_txn("5/255 rem", 8'd5, 8'd255, 1'b1);
    run_txn("255/255 quo", 8'd255, 8'd255, 1'b0);
    run_txn("254/255 rem", 8'd254, 8'd255, 1'b1);

    // Deselect mid-receive
    @(negedge clk);
    spi.mosi = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      spi.mosi = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    check("abort busy before deselect", {31'd0, busy}, 1);
    spi.nss[NSS] = 1'b1;
    spi.mosi     = 1'b0;
    @(negedge clk);
    check("abort idle after deselect", {31'd0, busy}, 0);
    spi.nss[NSS] = 1'b0;
    run_txn("200/9 quo", 8'd200, 8'd9, 1'b0);

    // Reset mid-COMPUTE
    p = '{mode: 1'b0, divisor: 8'd3, dividend: 8'd99};
    send_packet(p, t0);
    repeat (3) @(negedge clk);
    check("compute busy", {31'd0, busy}, 1);
    #2 rst = 1'b1;
    #1;
    check("midreset busy", {31'd0, busy}, 0);
    check("midreset miso", {31'd0, spi.miso}, 0);
    @(negedge clk);
    rst = 1'b0;
    run_txn("63/8 rem", 8'd63, 8'd8, 1'b1);

    for (int k = 0; k < 20; k++) begin
      a = 8'($urandom);
      b = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
      m = 1'($urandom_range(0, 1));
      run_txn($sformatf("rand%0d %0d/%0d m%0d", k, a, b, m), a, b, m);
    end

    repeat (5) @(negedge clk);
    check("queue drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
